psum_drain: RTL and testbench
=============================

Name: psum_drain

Overview:
- Downstream of the row of NUM_COLS PE arrays. Each PE array presents its 128-bit psum word on its word_o output.
- After the controller issues a clear, this block captures each column's word at the cycle that column's result becomes final. The columns finish on a staggered, diagonal schedule.
- It buffers the captured words and writes them to the output global buffer through a valid/ready write port, at consecutive addresses starting from a base address.
- It pulses done when the whole tile has been written.

Parameters:
NUM_COLS, 8, number of PE arrays (columns) drained per tile
WORD_WIDTH, 128, bits per PE-array output word (8 x DATA_WIDTH)
ADDR_WIDTH, 8, output global buffer address width
CAPTURE_LAT, 9, cycles from start_i to the cycle column 0's word_o is final (the clear ripples through 8 PEs, plus 1 cycle for the word_q register)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
start_i  in  1  one-cycle pulse, same cycle the clear is issued to column 0
base_addr_i  in  ADDR_WIDTH  first output address; sampled when start_i is accepted
words_i  in  NUM_COLS*WORD_WIDTH  concatenated PE-array word_o outputs; column k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]
busy_o  out  1  a tile is in progress
wr_valid_o  out  1  write request to the output buffer
wr_ready_i  in  1  output buffer accepts the write
wr_addr_o  out  ADDR_WIDTH  write address
wr_data_o  out  WORD_WIDTH  write data
done_o  out  1  one-cycle pulse after the last write handshake
err_o  out  1  one-cycle pulse when start_i is dropped because a tile is in progress

Behaviour:
- Reset:
  - Synchronous, active-low, on posedge clk_i when rst_ni=0.
  - All outputs go to 0: busy_o, wr_valid_o, wr_addr_o, wr_data_o, done_o, err_o.
  - State returns to IDLE; cnt, cap_ptr and rd_ptr are cleared.
  - The buffer contents need not be cleared.
  - Reset asserted mid-tile abandons the tile; no done_o is produced.
- State IDLE:
  - start_i=1: latch base_addr_i, set cnt=1, cap_ptr=0, rd_ptr=0, go to FILL.
- State FILL:
  - cnt increments every cycle.
  - When cnt == CAPTURE_LAT + cap_ptr: buf[cap_ptr] <= words_i column cap_ptr, and cap_ptr increments. Column k is therefore captured at the edge ending cycle CAPTURE_LAT+k, counting the start_i cycle as cycle 0.
  - When cap_ptr reaches NUM_COLS, go to DRAIN.
- State DRAIN:
  - Write out the remaining words only; no further captures.
  - When the final handshake occurs, go to IDLE.
- Write port (active in both FILL and DRAIN):
  - wr_valid_o = (rd_ptr < cap_ptr), registered.
  - wr_addr_o = base + rd_ptr, modulo 2^ADDR_WIDTH; the address wraps silently.
  - wr_data_o = buf[rd_ptr].
  - A handshake is wr_valid_o && wr_ready_i; each handshake increments rd_ptr.
  - Once wr_valid_o is high, wr_addr_o and wr_data_o are held stable until the handshake.
  - Words are written strictly in column order 0..NUM_COLS-1.
  - Capture never waits for wr_ready_i. The buffer holds all NUM_COLS words, so backpressure cannot lose data.
- Minimum latency:
  - First wr_valid_o at cycle CAPTURE_LAT+1.
  - With wr_ready_i tied to 1, the last handshake is at cycle CAPTURE_LAT+NUM_COLS.
  - done_o fires in the following cycle (cycle 18 with defaults).
- Completion:
  - Handshake on rd_ptr==NUM_COLS-1 gives done_o=1 for the next cycle only.
  - busy_o falls in that same next cycle.
- busy_o:
  - 1 from the cycle after start_i is accepted until the state returns to IDLE.
- start_i while busy_o=1:
  - Ignored; the tile in progress is unaffected.
  - err_o=1 for the next cycle.
- start_i in the same cycle as done_o:
  - Accepted, because the state is already IDLE.
- Pointer widths:
  - cap_ptr and rd_ptr are clog2(NUM_COLS)+1 bits.
  - cnt is clog2(CAPTURE_LAT+NUM_COLS)+1 bits.

Optional Feature:
- Macro: PSUM_DRAIN_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [15:0].
  - Counts the cycles with wr_valid_o=1 && wr_ready_i=0 during the current tile.
  - Cleared when start_i is accepted; saturates at 16'hFFFF; holds its value in IDLE.
  - Reset value 0.
- Undefined:
  - No port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Single tile, no backpressure:
  - Stimulus: reset, then start_i at cycle 0 with base=8'h10 and wr_ready_i=1. Drive column k to 128'h(k+1) repeated from cycle 9+k onward, and to garbage before that.
  - Required: writes at addresses 10..17 carry (k+1) patterns in cycles 10..17; done_o=1 at cycle 18 only; busy_o high for cycles 1..17.
- Backpressure:
  - Stimulus: as above, but wr_ready_i=0 for cycles 10..25.
  - Required: wr_valid_o and the first word stay stable through cycle 25; all 8 words are then written in order in cycles 26..33; done_o at 34; words_i changes after capture do not corrupt the data.
- Address wrap:
  - Stimulus: base=8'hFC.
  - Required: addresses FC, FD, FE, FF, 00, 01, 02, 03.
- Start while busy:
  - Stimulus: second start_i at cycle 5 with base=8'h40.
  - Required: err_o=1 at cycle 6; the tile completes with base 10 unchanged; exactly 8 writes.
- Reset mid-tile:
  - Stimulus: rst_ni=0 at cycle 12 for one cycle.
  - Required: all outputs 0 next cycle; no done_o; a new start_i then gives a clean 8-write tile.
- Back-to-back tiles and stall counter:
  - Stimulus: new start_i in the done_o cycle.
  - Required: the new tile is accepted with no err_o.
  - With PSUM_DRAIN_STALL_CNT_EN defined, the backpressure scenario gives stall_cnt_o=16.

Source files
------------

// File: rtl/psum_drain.sv
// Captures each PE column's psum word on its diagonal finish cycle and streams
// the tile to the output buffer. Define PSUM_DRAIN_STALL_CNT_EN to add stall_cnt_o.
module psum_drain #(
  parameter int NUM_COLS    = 8,
  parameter int WORD_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 8,
  parameter int CAPTURE_LAT = 9
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          base_addr_i,
  input  logic [NUM_COLS*WORD_WIDTH-1:0] words_i,
  output logic                           busy_o,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [ADDR_WIDTH-1:0]          wr_addr_o,
  output logic [WORD_WIDTH-1:0]          wr_data_o,
  output logic                           done_o,
  output logic                           err_o
`ifdef PSUM_DRAIN_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NUM_COLS) + 1;
  localparam int CNT_W = $clog2(CAPTURE_LAT + NUM_COLS) + 1;
  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        cap_ptr_q, cap_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    wr_valid_q, wr_valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    cap_en;
  logic                    handshake;

  logic [WORD_WIDTH-1:0]   col_words [NUM_COLS];
  logic [WORD_WIDTH-1:0]   mem_q [NUM_COLS];
  logic [IDX_W-1:0]        cap_idx;
  logic [IDX_W-1:0]        rd_idx;

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_cols
    assign col_words[k] = words_i[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign cap_idx   = cap_ptr_q[IDX_W-1:0];
  assign rd_idx    = rd_ptr_q[IDX_W-1:0];
  assign handshake = wr_valid_q && wr_ready_i;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_ptr_d = cap_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    base_d    = base_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cap_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          cnt_d     = CNT_W'(1);
          cap_ptr_d = '0;
          rd_ptr_d  = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Column cap_ptr finishes CAPTURE_LAT+cap_ptr cycles after the clear.
        if (cnt_q == CNT_W'(CAPTURE_LAT) + CNT_W'(cap_ptr_q)) begin
          cap_en    = 1'b1;
          cap_ptr_d = cap_ptr_q + PTR_W'(1);
          if (cap_ptr_d == PTR_W'(NUM_COLS)) state_d = DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      err_d = start_i;
      if (handshake) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (rd_ptr_q == PTR_W'(NUM_COLS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end

    wr_valid_d = (state_d != IDLE) && (rd_ptr_d < cap_ptr_d);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      base_q     <= '0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_ptr_q  <= cap_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      base_q     <= base_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the word buffer is not reset; wr_valid_o qualifies every entry that is read.
  always_ff @(posedge clk_i) begin
    if (cap_en) mem_q[cap_idx] <= col_words[cap_idx];
  end

  assign busy_o     = (state_q != IDLE);
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = base_q + ADDR_WIDTH'(rd_ptr_q);
  assign wr_data_o  = wr_valid_q ? mem_q[rd_idx] : '0;
  assign done_o     = done_q;
  assign err_o      = err_q;

`ifdef PSUM_DRAIN_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE) begin
      if (start_i) stall_cnt_d = '0;
    end else if (wr_valid_q && !wr_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// Randomised bench for psum_drain: a queue-based tile model checked every cycle,
// plus hand-computed latency/address/data expectations per scenario.
module tb_psum_drain;

  localparam int NC  = 8;
  localparam int W   = 128;
  localparam int AW  = 8;
  localparam int LAT = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [AW-1:0]   base_addr_i;
  logic [NC*W-1:0] words_i;
  logic            busy_o;
  logic            wr_valid_o;
  logic            wr_ready_i;
  logic [AW-1:0]   wr_addr_o;
  logic [W-1:0]    wr_data_o;
  logic            done_o;
  logic            err_o;
  logic [15:0]     stall_cnt;

  psum_drain dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .words_i     (words_i),
    .busy_o      (busy_o),
    .wr_valid_o  (wr_valid_o),
    .wr_ready_i  (wr_ready_i),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .done_o      (done_o),
    .err_o       (err_o)
`ifdef PSUM_DRAIN_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

`ifndef PSUM_DRAIN_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int st_cyc = -1000;
  int ready_mode = 0;   // 0: always ready, 1: stalled for ages 10..25, 2: random
  bit rnd_starts = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int k);
    return {16{8'(k + 1)}};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } exp_t;

  exp_t          exp_q[$];
  bit            m_busy  = 0;
  bit            m_done  = 0;
  bit            m_err   = 0;
  bit            m_zero  = 0;
  int            m_age   = 0;
  int            m_wr    = 0;
  logic [AW-1:0] m_base  = '0;
  int            m_stall = 0;

  // DUT-observed event log used by the literal expectations.
  int            hs_cyc[$];
  logic [AW-1:0] hs_addr[$];
  logic [W-1:0]  hs_data[$];
  int            done_cyc[$];
  int            err_cyc[$];

  task automatic clear_log();
    hs_cyc.delete(); hs_addr.delete(); hs_data.delete();
    done_cyc.delete(); err_cyc.delete();
  endtask

  initial begin
    @(posedge clk);
    forever begin
      // Model update for the edge that just occurred, from this cycle's inputs.
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_err = 0; m_zero = 1;
        m_wr = 0; m_stall = 0; exp_q.delete();
      end else begin
        bit nd, ne, v;
        nd = 0; ne = 0;
        m_zero = 0;
        v = m_busy && (exp_q.size() > 0);
        if (m_busy) begin
          ne = start_i;
          if (v && !wr_ready_i && m_stall < 16'hFFFF) m_stall++;
          if (v && wr_ready_i) begin
            void'(exp_q.pop_front());
            m_wr++;
            if (m_wr == NC) nd = 1;
          end
          if (m_age >= LAT && m_age < LAT + NC) begin
            exp_t e;
            e.a = AW'(m_base + (m_age - LAT));
            e.d = words_i[(m_age - LAT)*W +: W];
            exp_q.push_back(e);
          end
          m_age++;
          if (nd) m_busy = 0;
        end else if (start_i) begin
          m_busy = 1; m_age = 1; m_base = base_addr_i;
          m_wr = 0; m_stall = 0; exp_q.delete();
        end
        m_done = nd;
        m_err  = ne;
      end

      @(negedge clk);
      check("busy", W'(busy_o), W'(m_busy));
      check("wr_valid", W'(wr_valid_o), W'(m_busy && exp_q.size() > 0));
      if (m_busy && exp_q.size() > 0) begin
        check("wr_addr", W'(wr_addr_o), W'(exp_q[0].a));
        check("wr_data", wr_data_o, exp_q[0].d);
      end
      if (m_zero) begin
        check("rst_addr", W'(wr_addr_o), '0);
        check("rst_data", wr_data_o, '0);
      end
      check("done", W'(done_o), W'(m_done));
      check("err", W'(err_o), W'(m_err));
`ifdef PSUM_DRAIN_STALL_CNT_EN
      check("stall_cnt", W'(stall_cnt), W'(m_stall));
`endif
      if (wr_valid_o === 1'b1 && wr_ready_i === 1'b1) begin
        hs_cyc.push_back(cyc); hs_addr.push_back(wr_addr_o); hs_data.push_back(wr_data_o);
      end
      if (done_o === 1'b1) done_cyc.push_back(cyc);
      if (err_o === 1'b1)  err_cyc.push_back(cyc);

      @(posedge clk);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive();
    int age;
    age = cyc - st_cyc;
    for (int k = 0; k < NC; k++) begin
      if (age == LAT + k) words_i[k*W +: W] = pat(k);
      else words_i[k*W +: W] = {$urandom, $urandom, $urandom, $urandom};
    end
    case (ready_mode)
      0:       wr_ready_i = 1'b1;
      1:       wr_ready_i = !(age >= 10 && age <= 25);
      default: wr_ready_i = ($urandom_range(0, 3) != 0);
    endcase
    if (rnd_starts && busy_o && $urandom_range(0, 15) == 0) begin
      start_i     = 1'b1;
      base_addr_i = AW'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start_i = 1'b0;
    drive();
  endtask

  task automatic start_tile(input logic [AW-1:0] base);
    tick();
    start_i     = 1'b1;
    base_addr_i = base;
    st_cyc      = cyc;
  endtask

  task automatic wait_done(input int budget, input bit chain, input logic [AW-1:0] base2);
    bit got;
    got = 0;
    for (int n = 0; n < budget && !got; n++) begin
      tick();
      if (done_o === 1'b1) begin
        got = 1;
        if (chain) begin
          start_i     = 1'b1;
          base_addr_i = base2;
          st_cyc      = cyc;
        end
      end
    end
    check("done_timeout", W'(got), W'(1));
    @(negedge clk);
    #1;
  endtask

  initial begin
    int st;
    logic [AW-1:0] wrap_addrs [NC];
    wrap_addrs = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};

    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; wr_ready_i = 1'b1; words_i = '0;
    repeat (3) tick();
    check("rst_busy", W'(busy_o), '0);
    check("rst_valid", W'(wr_valid_o), '0);
    check("rst_done", W'(done_o), '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single tile, no backpressure.
    clear_log(); ready_mode = 0;
    start_tile(8'h10); st = st_cyc;
    wait_done(100, 0, '0);
    check("t1_nwr", W'(hs_cyc.size()), W'(8));
    check("t1_first_cyc", W'(hs_cyc[0] - st), W'(10));
    check("t1_last_cyc", W'(hs_cyc[7] - st), W'(17));
    check("t1_addr0", W'(hs_addr[0]), W'(8'h10));
    check("t1_addr7", W'(hs_addr[7]), W'(8'h17));
    check("t1_data0", hs_data[0], 128'h01010101010101010101010101010101);
    check("t1_data7", hs_data[7], 128'h08080808080808080808080808080808);
    check("t1_done_cyc", W'(done_cyc[0] - st), W'(18));
    check("t1_ndone", W'(done_cyc.size()), W'(1));
    repeat (3) tick();

    // Backpressure for cycles 10..25.
    clear_log(); ready_mode = 1;
    start_tile(8'h10); st = st_cyc;
    wait_done(100, 0, '0);
    check("t2_nwr", W'(hs_cyc.size()), W'(8));
    check("t2_first_cyc", W'(hs_cyc[0] - st), W'(26));
    check("t2_last_cyc", W'(hs_cyc[7] - st), W'(33));
    check("t2_data0", hs_data[0], 128'h01010101010101010101010101010101);
    check("t2_data5", hs_data[5], 128'h06060606060606060606060606060606);
    check("t2_done_cyc", W'(done_cyc[0] - st), W'(34));
`ifdef PSUM_DRAIN_STALL_CNT_EN
    check("t2_stall", W'(stall_cnt), W'(16));
`endif
    repeat (3) tick();

    // Address wrap.
    clear_log(); ready_mode = 0;
    start_tile(8'hFC);
    wait_done(100, 0, '0);
    check("t3_nwr", W'(hs_cyc.size()), W'(8));
    for (int i = 0; i < NC; i++) check($sformatf("t3_addr%0d", i), W'(hs_addr[i]), W'(wrap_addrs[i]));
    repeat (3) tick();

    // Start while busy.
    clear_log();
    start_tile(8'h10); st = st_cyc;
    repeat (5) tick();
    start_i = 1'b1; base_addr_i = 8'h40;
    wait_done(100, 0, '0);
    check("t4_nerr", W'(err_cyc.size()), W'(1));
    check("t4_err_cyc", W'(err_cyc[0] - st), W'(6));
    check("t4_nwr", W'(hs_cyc.size()), W'(8));
    check("t4_addr0", W'(hs_addr[0]), W'(8'h10));
    check("t4_addr7", W'(hs_addr[7]), W'(8'h17));
    repeat (3) tick();

    // Reset mid-tile, then a clean tile.
    clear_log();
    start_tile(8'h10);
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_busy", W'(busy_o), '0);
    check("t5_valid", W'(wr_valid_o), '0);
    repeat (30) tick();
    check("t5_ndone", W'(done_cyc.size()), '0);
    clear_log();
    start_tile(8'h20);
    wait_done(100, 0, '0);
    check("t5_nwr", W'(hs_cyc.size()), W'(8));
    check("t5_addr0", W'(hs_addr[0]), W'(8'h20));
    repeat (3) tick();

    // Back-to-back tiles: second start in the done cycle.
    clear_log();
    start_tile(8'h50);
    wait_done(100, 1, 8'h60);
    wait_done(100, 0, '0);
    check("t6_nerr", W'(err_cyc.size()), '0);
    check("t6_ndone", W'(done_cyc.size()), W'(2));
    check("t6_gap", W'(done_cyc[1] - done_cyc[0]), W'(18));
    check("t6_nwr", W'(hs_cyc.size()), W'(16));
    check("t6_addr8", W'(hs_addr[8]), W'(8'h60));
    repeat (3) tick();

    // Random backpressure, bases and stray starts.
    ready_mode = 2; rnd_starts = 1'b1;
    for (int t = 0; t < 12; t++) begin
      clear_log();
      start_tile(AW'($urandom));
      wait_done(400, 0, '0);
      check("rnd_nwr", W'(hs_cyc.size()), W'(8));
      repeat ($urandom_range(0, 4)) tick();
    end
    rnd_starts = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
